// File: rtl/regwrite_encoder.sv
// regwrite_encoder
// Turns a multi-hot write-back request vector into one register-write code
// per cycle for decoder4. The enable code is {~valid, index}. The winner is
// chosen round-robin after the last granted source, or by fixed lowest-index
// priority. A one-cycle mask keeps the source granted last cycle from being
// granted again before it has had a chance to drop its request.
module regwrite_encoder #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        stall,
    output logic [4:0]  enable,
    output logic [15:0] grant,
    output logic [4:0]  pending
);

    localparam logic [4:0] EN_IDLE = 5'b10000;

    logic [3:0]  ptr_q,     ptr_d;
    logic [15:0] last_q;
    logic [15:0] grant_q,   grant_d;
    logic [4:0]  enable_q,  enable_d;
    logic [4:0]  pending_q, pending_d;

    logic [15:0] ereq;
    logic [3:0]  start;
    logic [31:0] dbl;
    logic [15:0] rot;
    logic [4:0]  rr_hit;
    logic [4:0]  fp_hit;
    logic        win_vld;
    logic [3:0]  win_idx;
    logic [4:0]  req_cnt;

    // Number of set bits in a 16-bit vector (0..16 fits in 5 bits).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit as {found, index}; scanning downward lets the lowest win.
    function automatic logic [4:0] find_first(input logic [15:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    // Mask the source granted last cycle and rotate so the round-robin search
    // becomes a plain lowest-bit search starting just after ptr.
    always_comb begin
        ereq    = req & ~last_q;
        start   = ptr_q + 4'd1;
        dbl     = {ereq, ereq} >> start;
        rot     = dbl[15:0];
        rr_hit  = find_first(rot);
        fp_hit  = find_first(ereq);
        req_cnt = popcount16(ereq);
    end

    // Pick the winner for the configured priority scheme.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 4'd0;
        if (RR_EN != 0) begin
            win_vld = rr_hit[4];
            win_idx = start + rr_hit[3:0];
        end else begin
            win_vld = fp_hit[4];
            win_idx = fp_hit[3:0];
        end
    end

    // Next-state for grant, write code, pointer and waiting-request count.
    always_comb begin
        grant_d   = 16'd0;
        enable_d  = EN_IDLE;
        ptr_d     = ptr_q;
        pending_d = req_cnt;
        if (!stall && win_vld) begin
            grant_d   = 16'd1 << win_idx;
            enable_d  = {1'b0, win_idx};
            ptr_d     = win_idx;
            pending_d = req_cnt - 5'd1;
        end
    end

    // State and output registers; ptr resets to 15 so the first search starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= 4'hF;
            last_q    <= 16'd0;
            grant_q   <= 16'd0;
            enable_q  <= EN_IDLE;
            pending_q <= 5'd0;
        end else begin
            ptr_q     <= ptr_d;
            last_q    <= grant_d;
            grant_q   <= grant_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    assign enable  = enable_q;
    assign grant   = grant_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regwrite_encoder.sv
// Bench for regwrite_encoder: a round-robin and a fixed-priority instance
// share one stimulus stream and are compared every cycle against a
// behavioural model, with literal expectations for the documented scenarios.
module tb_regwrite_encoder;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] req   = 16'd0;
    logic        stall = 1'b0;

    logic [4:0]  en_rr, en_fp;
    logic [15:0] gr_rr, gr_fp;
    logic [4:0]  pd_rr, pd_fp;

    int n_checks = 0;
    int n_errors = 0;

    regwrite_encoder #(.RR_EN(1)) dut_rr (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .enable(en_rr), .grant(gr_rr), .pending(pd_rr)
    );

    regwrite_encoder #(.RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .enable(en_fp), .grant(gr_fp), .pending(pd_fp)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] g;
        logic [4:0]  en;
        logic [4:0]  pend;
        logic [3:0]  ptr;
    } mstep_t;

    mstep_t m_st [2];

    // Winner: first set bit in search order, or -1 when nothing is eligible.
    function automatic int f_win(input logic [15:0] e, input int ptr, input bit rr);
        int idx;
        for (int k = 0; k < 16; k++) begin
            idx = rr ? (ptr + 1 + k) % 16 : k;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mstep_t f_step(input logic [15:0] r, input mstep_t cur,
                                      input logic st, input bit rr);
        mstep_t s;
        logic [15:0] e;
        int w;
        int cnt;
        e   = r & ~cur.g;
        w   = f_win(e, int'(cur.ptr), rr);
        cnt = $countones(e);
        if (!st && w >= 0) begin
            s.g    = 16'd1 << w;
            s.en   = {1'b0, 4'(w)};
            s.ptr  = 4'(w);
            s.pend = 5'(cnt - 1);
        end else begin
            s.g    = 16'd0;
            s.en   = 5'b10000;
            s.ptr  = cur.ptr;
            s.pend = 5'(cnt);
        end
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_st[c] <= '{g: 16'd0, en: 5'b10000, pend: 5'd0, ptr: 4'hF};
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_st[c] <= f_step(req, m_st[c], stall, (c == 0));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always begin
        @(negedge clk);
        chk("rr_enable",  32'(en_rr), 32'(m_st[0].en));
        chk("rr_grant",   32'(gr_rr), 32'(m_st[0].g));
        chk("rr_pending", 32'(pd_rr), 32'(m_st[0].pend));
        chk("fp_enable",  32'(en_fp), 32'(m_st[1].en));
        chk("fp_grant",   32'(gr_fp), 32'(m_st[1].g));
        chk("fp_pending", 32'(pd_fp), 32'(m_st[1].pend));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] r;
        // Reset with everything requesting: outputs clear without any clock edge.
        req = 16'hFFFF;
        #1 reset = 1'b1;
        #1;
        chk("reset_enable",  32'(en_rr), 32'h10);
        chk("reset_grant",   32'(gr_rr), 32'h0);
        chk("reset_pending", 32'(pd_rr), 32'h0);
        chk("reset_fp_enable", 32'(en_fp), 32'h10);
        tick();
        tick();
        reset = 1'b0;
        req   = 16'd0;

        // Single source, dropped once granted.
        req = 16'h0020;
        tick();
        chk("single_grant",   32'(gr_rr), 32'h0020);
        chk("single_enable",  32'(en_rr), 32'h05);
        chk("single_pending", 32'(pd_rr), 32'h0);
        req = 16'd0;
        tick();
        chk("single_after_enable", 32'(en_rr), 32'h10);
        chk("single_after_grant",  32'(gr_rr), 32'h0);

        // Round robin between 0 and 15 from a fresh reset.
        reset = 1'b1;
        #1 reset = 1'b0;
        req = 16'h8001;
        tick();
        chk("rr1_grant",   32'(gr_rr), 32'h0001);
        chk("rr1_enable",  32'(en_rr), 32'h00);
        chk("rr1_pending", 32'(pd_rr), 32'h1);
        tick();
        chk("rr2_grant",  32'(gr_rr), 32'h8000);
        chk("rr2_enable", 32'(en_rr), 32'h0F);
        tick();
        chk("rr3_enable", 32'(en_rr), 32'h00);
        tick();
        chk("rr4_enable", 32'(en_rr), 32'h0F);

        // Fixed priority picks the lowest of 4..7.
        req = 16'h00F0;
        tick();
        chk("fp_grant_lit",   32'(gr_fp), 32'h0010);
        chk("fp_enable_lit",  32'(en_fp), 32'h04);
        chk("fp_pending_lit", 32'(pd_fp), 32'h3);
        req = 16'd0;
        tick();

        // Stall holds off the grant; it appears one edge after stall drops.
        req   = 16'h0100;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_enable",  32'(en_rr), 32'h10);
            chk("stall_pending", 32'(pd_rr), 32'h1);
        end
        stall = 1'b0;
        tick();
        chk("unstall_enable", 32'(en_rr), 32'h08);
        chk("unstall_grant",  32'(gr_rr), 32'h0100);
        req = 16'd0;
        tick();

        // Wrap: after granting 14, 14 is masked and 15 idle, so 0 wins.
        req = 16'h4000;
        tick();
        chk("wrap_pre_grant", 32'(gr_rr), 32'h4000);
        req = 16'h4003;
        tick();
        chk("wrap_grant",   32'(gr_rr), 32'h0001);
        chk("wrap_enable",  32'(en_rr), 32'h00);
        chk("wrap_pending", 32'(pd_rr), 32'h1);
        req = 16'd0;
        tick();

        // Reset asserted while a grant is on the outputs.
        req = 16'hFFFF;
        tick();
        reset = 1'b1;
        #1;
        chk("midreset_enable",  32'(en_rr), 32'h10);
        chk("midreset_grant",   32'(gr_rr), 32'h0);
        chk("midreset_pending", 32'(pd_rr), 32'h0);
        #1 reset = 1'b0;
        req = 16'd0;

        // Randomized traffic with stalls and occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0: r = 16'd0;
                1: r = 16'($urandom);
                2: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: r = 16'd1 << ($urandom % 16);
            endcase
            req   = r;
            stall = (($urandom % 5) == 0);
            if (($urandom % 60) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        req   = 16'd0;
        stall = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regwrite_encoder.md
# regwrite_encoder

Round-robin request encoder for register-file write-back. Up to 16 write sources raise one request line each. The block grants one source per cycle and emits the 5-bit register-write enable code consumed by `decoder4`: MSB low means write, low four bits select the register. MSB high means no write, and the decoder then drives all-zero enables. It sits between the write-back sources and `decoder4`, turning a multi-hot request vector into a single legal write code with fair arbitration.

## Interface
Parameters:
- `RR_EN`, default 1: 1 = round-robin priority; 0 = fixed priority, lowest index wins.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 16: request vector, bit i = source i wants to write register i. Multi-hot allowed.
- `stall` input 1: register file not accepting writes. No grant is issued while high.
- `enable` output 5: registered write code {~valid, index[3:0]}.
- `grant` output 16: registered one-hot grant, pulsed for one cycle.
- `pending` output 5: registered count of request bits still waiting after this cycle's grant (0..16).

## Operation
- Internal state:
  - `ptr[3:0]`: index of the last granted source.
  - `last[15:0]`: copy of `grant`, used as a one-cycle mask.
- Effective request: `ereq = req & ~last`. A granted source must drop its request in the cycle after it sees `grant`. The mask guarantees no double grant of the same index on consecutive cycles.
- Search, RR_EN=1: scan `ereq` starting at index ptr+1, ascending, wrapping 15→0. The first set bit wins.
- Search, RR_EN=0: the lowest set bit of `ereq` wins. `ptr` is still updated but not used.
- On each rising edge when not in reset:
  - If `stall`=0 and `ereq`≠0, with winner i:
    - `grant` = 1<<i
    - `enable` = {1'b0, i}
    - `ptr` = i
  - Otherwise:
    - `grant` = 0
    - `enable` = 5'b10000
    - `ptr` unchanged
  - In both cases, `pending` = popcount(`ereq`) minus (1 if a grant issued, else 0).
- `grant` is only ever 0 or one-hot. `enable[4]`=0 if and only if `grant`≠0, and `enable[3:0]` is then the index of the set grant bit.
- When `enable[4]`=1, `enable[3:0]` is 0.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - `enable` = 5'b10000
  - `grant` = 0
  - `pending` = 0
  - `ptr` = 4'hF, so the first round-robin search starts at index 0
  - `last` = 0
- Latency: `req` sampled at edge k; `grant`/`enable` valid after edge k, for one cycle.
- Throughput: one grant per cycle while any unmasked request exists.
  - A lone source holding `req` continuously is granted every other cycle because of the mask.
- Stall:
  - Sampled at the same edge as `req`.
  - While high: no grant, and `ptr`/`last` behave as in an idle cycle. `last` clears, so the source granted in the cycle before the stall becomes eligible again.
  - After `stall` drops, the first grant appears one edge later.
- Reset asserted mid-grant: outputs clear asynchronously. The write in flight is lost, and the source must re-request.
- Simultaneous requests: exactly one winner per cycle. Losers stay counted in `pending`.
- Wrap-around: with ptr=15, the search order is 0,1,…,15. With ptr=14, the order is 15,0,1,…,14.

## Test plan
- Reset: assert `reset` with `req`=16'hFFFF → immediately `enable`=5'b10000, `grant`=0, `pending`=0, with no clock edge required.
- Single source:
  - `req`=16'h0020 for one cycle, dropped on seeing `grant` → next cycle `grant`=16'h0020, `enable`=5'b00101; following cycle `enable`=5'b10000.
- Round-robin:
  - RR_EN=1, `req`=16'h8001 held for 4 cycles after reset → grants 0, 15, 0, 15; `enable`=00000, 01111, 00000, 01111.
- Fixed priority:
  - RR_EN=0, `req`=16'h00F0 → `grant`=16'h0010, `enable`=5'b00100, `pending`=3.
- Stall:
  - `req`=16'h0100 with `stall`=1 for 3 cycles → `enable` stays 5'b10000, `pending`=1.
  - `stall` drops → one edge later `enable`=5'b01000, `grant`=16'h0100.
- Wrap:
  - After a grant to 14 (ptr=14), `req`=16'h4003 → next `grant`=16'h0001. 14 is masked, 15 is not requested, so the search wraps to 0.
